// File: rtl/cdb_result_arb_pkg.sv
// Shared result-bus types and sizes used by the execute pipes, the IQs, the ROB and the CDB
// arbiter. CDB_COUNT and EXE_SRC_COUNT live here so that all of those blocks agree on them.
package cdb_result_arb_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned ROB_ID_W      = 6;
    localparam int unsigned EXE_SRC_COUNT = 4;
    localparam int unsigned CDB_COUNT     = 2;

    typedef logic [XLEN-1:0]     word_t;
    typedef logic [ROB_ID_W-1:0] rob_id_t;

    typedef struct packed {
        rob_id_t rob_id;
        word_t   w_data;
        logic    w_reg;
    } cdb_info_t;

endpackage

// File: rtl/result_fifo.sv
// Small per-source result FIFO. Ready depends only on the registered count. The head is read
// straight from storage, so there is no bypass from push to head.
module result_fifo
    import cdb_result_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      push_valid_i,
    input  cdb_info_t push_data_i,
    output logic      push_ready_o,
    output cdb_info_t head_o,
    output logic      nonempty_o,
    input  logic      pop_i
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    cdb_info_t       mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push;
    logic            pop;

    assign push_ready_o = (count_q != CW'(FIFO_DEPTH));
    assign nonempty_o   = (count_q != '0);
    assign push         = push_valid_i & push_ready_o;
    assign pop          = pop_i & nonempty_o;
    assign head_o       = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left uncleared; the count alone marks which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/cdb_result_arb.sv
// Buffers execute-pipe results in per-source FIFOs. Each cycle it grants up to CDB_COUNT FIFO heads,
// in round-robin order, onto the common data bus that feeds the ROB and the IQ forwarding ports.
module cdb_result_arb
    import cdb_result_arb_pkg::*;
#(
    parameter int unsigned SRC_COUNT  = cdb_result_arb_pkg::EXE_SRC_COUNT,
    parameter int unsigned CDB_COUNT  = cdb_result_arb_pkg::CDB_COUNT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [SRC_COUNT-1:0] src_valid_i,
    input  cdb_info_t            src_data_i      [SRC_COUNT],
    output logic [SRC_COUNT-1:0] src_ready_o,
    output cdb_info_t            cdb_o           [CDB_COUNT],
    output logic [CDB_COUNT-1:0] cdb_valid_o,
    output word_t                cdb_data_o      [CDB_COUNT],
    output rob_id_t              cdb_reg_id_o    [CDB_COUNT],
    output logic [CDB_COUNT-1:0] cdb_fwd_valid_o
);

    localparam int unsigned SW = $clog2(SRC_COUNT);

    cdb_info_t            head     [SRC_COUNT];
    logic [SRC_COUNT-1:0] nonempty;
    logic [SRC_COUNT-1:0] grant;
    logic [SW-1:0]        lane_src [CDB_COUNT];
    logic [SW-1:0]        scan_idx;
    logic [SW-1:0]        rr_q, rr_d;

    for (genvar g = 0; g < SRC_COUNT; g++) begin : g_fifo
        result_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk          (clk),
            .rst_n        (rst_n),
            .flush        (flush),
            .push_valid_i (src_valid_i[g]),
            .push_data_i  (src_data_i[g]),
            .push_ready_o (src_ready_o[g]),
            .head_o       (head[g]),
            .nonempty_o   (nonempty[g]),
            .pop_i        (grant[g])
        );
    end

    // Each lane takes the next non-empty, not-yet-granted source in scan order from rr_q. The
    // last assignment to rr_d therefore follows the final grant.
    always_comb begin
        grant       = '0;
        cdb_valid_o = '0;
        rr_d        = rr_q;
        scan_idx    = '0;
        for (int unsigned k = 0; k < CDB_COUNT; k++) lane_src[k] = '0;
        for (int unsigned k = 0; k < CDB_COUNT; k++) begin
            for (int unsigned j = 0; j < SRC_COUNT; j++) begin
                scan_idx = rr_q + SW'(j);
                if (!cdb_valid_o[k] && nonempty[scan_idx] && !grant[scan_idx]) begin
                    grant[scan_idx] = 1'b1;
                    cdb_valid_o[k]  = 1'b1;
                    lane_src[k]     = scan_idx;
                    rr_d            = scan_idx + SW'(1);
                end
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < CDB_COUNT; k++) begin
            cdb_o[k]           = cdb_valid_o[k] ? head[lane_src[k]] : '0;
            cdb_data_o[k]      = cdb_o[k].w_data;
            cdb_reg_id_o[k]    = cdb_o[k].rob_id;
            cdb_fwd_valid_o[k] = cdb_valid_o[k] & cdb_o[k].w_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else if (flush) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: tb/tb_cdb_result_arb.sv
// Directed bench for cdb_result_arb: reset, single result, 4-way burst, RR wrap, streaming,
// saturation fairness, and flush / async reset of a full FIFO.
module tb_cdb_result_arb;
    import cdb_result_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [3:0] src_valid;
    cdb_info_t  src_data [4];
    logic [3:0] src_ready;
    cdb_info_t  cdb      [2];
    logic [1:0] cdb_valid;
    word_t      cdb_data [2];
    rob_id_t    cdb_reg_id [2];
    logic [1:0] cdb_fwd_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cdb_result_arb #(
        .SRC_COUNT  (4),
        .CDB_COUNT  (2),
        .FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .src_valid_i     (src_valid),
        .src_data_i      (src_data),
        .src_ready_o     (src_ready),
        .cdb_o           (cdb),
        .cdb_valid_o     (cdb_valid),
        .cdb_data_o      (cdb_data),
        .cdb_reg_id_o    (cdb_reg_id),
        .cdb_fwd_valid_o (cdb_fwd_valid)
    );

    function automatic cdb_info_t mk(input rob_id_t id, input word_t d, input logic w);
        cdb_info_t r;
        r.rob_id = id;
        r.w_data = d;
        r.w_reg  = w;
        return r;
    endfunction

    task automatic do_flush();
        flush     = 1'b1;
        src_valid = '0;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        src_valid = '0;
        for (int s = 0; s < 4; s++) src_data[s] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (src_ready !== 4'b1111) begin
                errors++; $display("FAIL reset_ready c%0d: got %b want 1111", c, src_ready);
            end
            checks++;
            if (cdb_valid !== 2'b00) begin
                errors++; $display("FAIL reset_valid c%0d: got %b want 00", c, cdb_valid);
            end
            checks++;
            if (cdb_data[0] !== 32'h0 || cdb_fwd_valid !== 2'b00) begin
                errors++;
                $display("FAIL reset_data c%0d: got %h/%b want 0/00", c, cdb_data[0], cdb_fwd_valid);
            end
        end
    endtask

    task automatic test_single();
        do_flush();
        src_data[0] = mk(6'd5, 32'hDEAD_BEEF, 1'b1);
        src_valid   = 4'b0001;
        checks++;
        if (cdb_valid !== 2'b00) begin
            errors++; $display("FAIL single_no_bypass: got %b want 00", cdb_valid);
        end
        @(negedge clk);
        src_valid = '0;
        checks++;
        if (cdb_valid !== 2'b01) begin
            errors++; $display("FAIL single_valid: got %b want 01", cdb_valid);
        end
        checks++;
        if (cdb_reg_id[0] !== 6'd5 || cdb_data[0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_data: got %0d/%h want 5/deadbeef", cdb_reg_id[0], cdb_data[0]);
        end
        checks++;
        if (cdb_fwd_valid !== 2'b01 || cdb_data[1] !== 32'h0) begin
            errors++;
            $display("FAIL single_fwd: got %b/%h want 01/0", cdb_fwd_valid, cdb_data[1]);
        end
        @(negedge clk);
        checks++;
        if (cdb_valid !== 2'b00) begin
            errors++; $display("FAIL single_idle: got %b want 00", cdb_valid);
        end
    endtask

    task automatic test_all_four();
        do_flush();
        for (int s = 0; s < 4; s++) src_data[s] = mk(rob_id_t'(10 + s), 32'h1000 + s, 1'b1);
        src_valid = 4'b1111;
        @(negedge clk);
        src_valid = '0;
        checks++;
        if (cdb_valid !== 2'b11 || cdb_reg_id[0] !== 6'd10 || cdb_reg_id[1] !== 6'd11) begin
            errors++;
            $display("FAIL all4_first: got %b %0d %0d want 11 10 11",
                     cdb_valid, cdb_reg_id[0], cdb_reg_id[1]);
        end
        @(negedge clk);
        checks++;
        if (cdb_valid !== 2'b11 || cdb_reg_id[0] !== 6'd12 || cdb_reg_id[1] !== 6'd13) begin
            errors++;
            $display("FAIL all4_second: got %b %0d %0d want 11 12 13",
                     cdb_valid, cdb_reg_id[0], cdb_reg_id[1]);
        end
        @(negedge clk);
        checks++;
        if (cdb_valid !== 2'b00) begin
            errors++; $display("FAIL all4_idle: got %b want 00", cdb_valid);
        end
    endtask

    // Source 2 alone moves rr to 3; then 0,1,3 compete and the scan wraps 3 -> 0 -> 1.
    task automatic test_wrap();
        do_flush();
        src_data[2] = mk(6'd2, 32'h2222, 1'b0);
        src_valid   = 4'b0100;
        @(negedge clk);
        checks++;
        if (cdb_valid !== 2'b01 || cdb_reg_id[0] !== 6'd2 || cdb_fwd_valid !== 2'b00) begin
            errors++;
            $display("FAIL wrap_src2: got %b %0d %b want 01 2 00",
                     cdb_valid, cdb_reg_id[0], cdb_fwd_valid);
        end
        src_data[0] = mk(6'd40, 32'h40, 1'b1);
        src_data[1] = mk(6'd41, 32'h41, 1'b1);
        src_data[3] = mk(6'd43, 32'h43, 1'b1);
        src_valid   = 4'b1011;
        @(negedge clk);
        src_valid = '0;
        checks++;
        if (cdb_valid !== 2'b11 || cdb_reg_id[0] !== 6'd43 || cdb_reg_id[1] !== 6'd40) begin
            errors++;
            $display("FAIL wrap_order: got %b %0d %0d want 11 43 40",
                     cdb_valid, cdb_reg_id[0], cdb_reg_id[1]);
        end
        @(negedge clk);
        checks++;
        if (cdb_valid !== 2'b01 || cdb_reg_id[0] !== 6'd41) begin
            errors++;
            $display("FAIL wrap_tail: got %b %0d want 01 41", cdb_valid, cdb_reg_id[0]);
        end
        @(negedge clk);
        checks++;
        if (cdb_valid !== 2'b00) begin
            errors++; $display("FAIL wrap_idle: got %b want 00", cdb_valid);
        end
    endtask

    task automatic test_stream();
        do_flush();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                checks++;
                if (cdb_valid !== 2'b01 || cdb_reg_id[0] !== rob_id_t'(20 + i - 1)) begin
                    errors++;
                    $display("FAIL stream_out i%0d: got %b %0d want 01 %0d",
                             i, cdb_valid, cdb_reg_id[0], 20 + i - 1);
                end
            end
            checks++;
            if (src_ready[1] !== 1'b1) begin
                errors++; $display("FAIL stream_ready i%0d: got %b want 1", i, src_ready[1]);
            end
            src_data[1] = mk(rob_id_t'(20 + i), word_t'(i), 1'b0);
            src_valid   = 4'b0010;
            @(negedge clk);
        end
        src_valid = '0;
        checks++;
        if (cdb_valid !== 2'b01 || cdb_reg_id[0] !== 6'd29 || cdb_fwd_valid !== 2'b00) begin
            errors++;
            $display("FAIL stream_last: got %b %0d %b want 01 29 00",
                     cdb_valid, cdb_reg_id[0], cdb_fwd_valid);
        end
        @(negedge clk);
        checks++;
        if (cdb_valid !== 2'b00) begin
            errors++; $display("FAIL stream_idle: got %b want 00", cdb_valid);
        end
    endtask

    // rob_id = {source, per-source sequence}; w_reg = source[0].
    task automatic test_saturate();
        int push_cnt [4];
        int pop_cnt  [4];
        int grants   [4];
        int last_gnt [4];
        int src;
        int seq;
        do_flush();
        for (int s = 0; s < 4; s++) begin
            push_cnt[s] = 0; pop_cnt[s] = 0; grants[s] = 0; last_gnt[s] = -1;
        end
        for (int s = 0; s < 4; s++) begin
            src_data[s] = mk(rob_id_t'(s * 16 + push_cnt[s]), 32'hA000_0000 + s * 256 + push_cnt[s],
                             s[0]);
            if (src_ready[s]) push_cnt[s]++;
        end
        src_valid = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (cdb_valid !== 2'b11) begin
                errors++; $display("FAIL sat_valid c%0d: got %b want 11", c, cdb_valid);
            end
            for (int k = 0; k < 2; k++) begin
                src = int'(cdb_reg_id[k][5:4]);
                seq = int'(cdb_reg_id[k][3:0]);
                checks++;
                if (seq !== (pop_cnt[src] & 15) || cdb_fwd_valid[k] !== src[0]) begin
                    errors++;
                    $display("FAIL sat_order c%0d lane%0d: src %0d seq %0d fwd %b want seq %0d fwd %b",
                             c, k, src, seq, cdb_fwd_valid[k], pop_cnt[src] & 15, src[0]);
                end
                if (last_gnt[src] >= 0) begin
                    checks++;
                    if (c - last_gnt[src] > 2) begin
                        errors++;
                        $display("FAIL sat_starve src%0d: got gap %0d want <=2",
                                 src, c - last_gnt[src]);
                    end
                end
                pop_cnt[src]++;
                grants[src]++;
                last_gnt[src] = c;
            end
            for (int s = 0; s < 4; s++) begin
                src_data[s] = mk(rob_id_t'(s * 16 + (push_cnt[s] & 15)),
                                 32'hA000_0000 + s * 256 + push_cnt[s], s[0]);
                if (src_ready[s]) push_cnt[s]++;
            end
        end
        src_valid = '0;
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (grants[s] != 8) begin
                errors++; $display("FAIL sat_grants src%0d: got %0d want 8", s, grants[s]);
            end
        end
    endtask

    task automatic test_flush_full();
        do_flush();
        for (int s = 0; s < 4; s++) src_data[s] = mk(rob_id_t'(50 + s), 32'h5000 + s, 1'b1);
        src_valid = 4'b1111;
        repeat (2) @(negedge clk);
        checks++;
        if (src_ready !== 4'b0011) begin
            errors++; $display("FAIL full_ready: got %b want 0011", src_ready);
        end
        flush = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        src_valid = '0;
        checks++;
        if (src_ready !== 4'b1111 || cdb_valid !== 2'b00) begin
            errors++;
            $display("FAIL flush_state: got %b %b want 1111 00", src_ready, cdb_valid);
        end
        checks++;
        if (cdb_data[0] !== 32'h0 || cdb_data[1] !== 32'h0 || cdb_fwd_valid !== 2'b00) begin
            errors++;
            $display("FAIL flush_data: got %h %h %b want 0 0 00",
                     cdb_data[0], cdb_data[1], cdb_fwd_valid);
        end
        src_valid = 4'b1111;
        repeat (2) @(negedge clk);
        checks++;
        if (src_ready !== 4'b0011) begin
            errors++; $display("FAIL full_ready2: got %b want 0011", src_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (src_ready !== 4'b1111 || cdb_valid !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: got %b %b want 1111 00", src_ready, cdb_valid);
        end
        @(negedge clk);
        src_valid = '0;
        rst_n     = 1'b1;
        @(negedge clk);
        checks++;
        if (src_ready !== 4'b1111 || cdb_valid !== 2'b00) begin
            errors++;
            $display("FAIL post_reset: got %b %b want 1111 00", src_ready, cdb_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_stream();
        test_saturate();
        test_flush_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
